// File: rtl/fp_div_arbiter_if.sv
// Handshake bundle for fp_div_arbiter: two requester channels and one
// response channel. The master side is the ALU issue logic / response
// consumer; the slave side is the arbiter.
interface fp_div_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_exception;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_exception
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_exception
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one combinational single-precision divider between
// two requesters. Requests are granted round-robin in IDLE, the operands are
// held on div_a_o/div_b_o for SETTLE_CYCLES cycles (WAIT), then the divider
// outputs are registered into the response channel (DONE) until consumed.
// SETTLE_CYCLES must be 1..15 and 2**CNT_W must exceed SETTLE_CYCLES.
// Optional feature macro: FP_DIV_ZERO_BYPASS_EN -- a divisor of +/-0 skips
// WAIT and answers with a signed infinity and the exception flag set.
module fp_div_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    fp_div_arbiter_if.slave    bus,
    output logic [31:0]        div_a_o,
    output logic [31:0]        div_b_o,
    input  logic [31:0]        div_result_i,
    input  logic               div_exception_i,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        div_a_q, div_a_d;
    logic [31:0]        div_b_q, div_b_d;
    logic               id_q, id_d;
    logic               last_grant_q, last_grant_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_exception_q, rsp_exception_d;

    logic               grant_valid;
    logic               grant_id;
    logic               handshake;
    logic [31:0]        grant_a;
    logic [31:0]        grant_b;

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_q;
        end else if (bus.req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign handshake      = (state_q == IDLE) && grant_valid;
    assign bus.req0_ready = handshake && !grant_id;
    assign bus.req1_ready = handshake && grant_id;
    assign grant_a        = grant_id ? bus.req1_a : bus.req0_a;
    assign grant_b        = grant_id ? bus.req1_b : bus.req0_b;

    // Next-state and datapath updates for the IDLE -> WAIT -> DONE sequence.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // signal unassigned; otherwise synthesis would infer latches.
        state_d         = state_q;
        cnt_d           = cnt_q;
        div_a_d         = div_a_q;
        div_b_d         = div_b_q;
        id_d            = id_q;
        last_grant_d    = last_grant_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_result_d    = rsp_result_q;
        rsp_exception_d = rsp_exception_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    div_a_d      = grant_a;
                    div_b_d      = grant_b;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
                    state_d      = WAIT;
`ifdef FP_DIV_ZERO_BYPASS_EN
                    // Division by +/-0 needs no settle time: answer directly.
                    if (grant_b[30:0] == 31'd0) begin
                        rsp_result_d    = {grant_a[31] ^ grant_b[31], 8'hFF, 23'd0};
                        rsp_exception_d = 1'b1;
                        rsp_id_d        = grant_id;
                        rsp_valid_d     = 1'b1;
                        state_d         = DONE;
                    end
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_result_d    = div_result_i;
                    rsp_exception_d = div_exception_i;
                    rsp_id_d        = id_q;
                    rsp_valid_d     = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            div_a_q         <= '0;
            div_b_q         <= '0;
            id_q            <= 1'b0;
            last_grant_q    <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_result_q    <= '0;
            rsp_exception_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            div_a_q         <= div_a_d;
            div_b_q         <= div_b_d;
            id_q            <= id_d;
            last_grant_q    <= last_grant_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_result_q    <= rsp_result_d;
            rsp_exception_q <= rsp_exception_d;
        end
    end

    assign div_a_o           = div_a_q;
    assign div_b_o           = div_b_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_exception = rsp_exception_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Self-checking bench for fp_div_arbiter. A behavioural divider stands in for
// the datapath; a transaction-level model (round-robin rule, expected latency,
// expected response) predicts every response.
module tb_fp_div_arbiter;

    localparam int S = 4;
`ifdef FP_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_result;
    logic        div_exception;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic last_grant_m;

    always #5 clk = ~clk;

    fp_div_arbiter_if bus ();

    // Stand-in divider: IEEE-like special cases, one known quotient, and an
    // arbitrary but deterministic mix for everything else.
    function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
        if (b[30:0] == 31'd0) begin
            if (a[30:0] == 31'd0) return {1'b1, 32'h7FC00000};
            return {1'b1, a[31] ^ b[31], 8'hFF, 23'd0};
        end
        if (a[30:0] == 31'd0) return {1'b0, a[31] ^ b[31], 31'd0};
        if (a == 32'hC0B33333 && b == 32'h40133333) return {1'b0, 32'hC01BD37A};
        return {a[0] & b[0], a ^ {b[15:0], b[31:16]} ^ 32'h9E3779B9};
    endfunction

    assign {div_exception, div_result} = div_model(div_a, div_b);

    fp_div_arbiter #(
        .SETTLE_CYCLES (S),
        .CNT_W         (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .div_a_o         (div_a),
        .div_b_o         (div_b),
        .div_result_i    (div_result),
        .div_exception_i (div_exception),
        .busy_o          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: raise the valids in vmask, predict the grant, follow it
    // through to the response, apply `hold` cycles of backpressure, consume.
    task automatic run_op(input logic [1:0] vmask, input int hold, input string tag);
        logic        gid;
        logic [31:0] ga, gb;
        logic [32:0] exp;
        int          exp_lat, lat;
        bit          got;
        logic        sv0, sv1;

        bus.rsp_ready  = (hold == 0);
        bus.req0_valid = vmask[0];
        bus.req1_valid = vmask[1];
        gid = (&vmask) ? ~last_grant_m : vmask[1];

        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " handshake"}, 32'(got), 32'd1);
        if (!got) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            return;
        end
        check({tag, " ready pair"}, {30'd0, bus.req1_ready, bus.req0_ready},
              gid ? 32'd2 : 32'd1);
        last_grant_m = gid;
        ga = gid ? bus.req1_a : bus.req0_a;
        gb = gid ? bus.req1_b : bus.req0_b;
        if (BYPASS && gb[30:0] == 31'd0) begin
            exp     = {1'b1, ga[31] ^ gb[31], 8'hFF, 23'd0};
            exp_lat = 1;
        end else begin
            exp     = div_model(ga, gb);
            exp_lat = S + 1;
        end

        @(posedge clk);
        #1;
        if (gid) bus.req1_valid = 1'b0;
        else     bus.req0_valid = 1'b0;

        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(busy), 32'd1);
            if (k == 1) begin
                check({tag, " div_a held"}, div_a, ga);
                check({tag, " div_b held"}, div_b, gb);
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        check({tag, " rsp_valid seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(gid));
        check({tag, " rsp_result"}, bus.rsp_result, exp[31:0]);
        check({tag, " rsp_exception"}, 32'(bus.rsp_exception), 32'(exp[32]));

        // Backpressure: the response must stay frozen and no request may be
        // accepted, even with both requesters shouting.
        sv0 = bus.req0_valid;
        sv1 = bus.req1_valid;
        for (int i = 0; i < hold; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            @(negedge clk);
            check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold rsp_result"}, bus.rsp_result, exp[31:0]);
            check({tag, " hold rsp_id"}, 32'(bus.rsp_id), 32'(gid));
            check({tag, " hold ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        end
        bus.req0_valid = sv0;
        bus.req1_valid = sv1;

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " rsp consumed"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  vm;
        bit          got;

        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset rsp_result", bus.rsp_result, 32'd0);
        check("reset rsp_exception", 32'(bus.rsp_exception), 32'd0);
        check("reset div_a", div_a, 32'd0);
        check("reset div_b", div_b, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        last_grant_m = 1'b1;
        @(negedge clk);

        // Contention: both requesters stay valid; only the winner reloads.
        bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_a = $urandom; bus.req1_b = $urandom;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 0, $sformatf("contend%0d", i));
            if (last_grant_m) begin
                bus.req1_a = $urandom; bus.req1_b = $urandom;
            end else begin
                bus.req0_a = $urandom; bus.req0_b = $urandom;
            end
        end

        // Single directed op: -5.6 / 2.3.
        bus.req0_a = 32'hC0B33333; bus.req0_b = 32'h40133333;
        run_op(2'b01, 0, "single");

        // Backpressure for 10 cycles on a requester-1 op.
        bus.req1_a = $urandom; bus.req1_b = $urandom;
        run_op(2'b10, 10, "backpressure");

        // Divide by zero and zero dividend.
        bus.req1_a = 32'h40B33333; bus.req1_b = 32'h00000000;
        run_op(2'b10, 0, "divzero");
        bus.req0_a = 32'h00000000; bus.req0_b = 32'h40B33333;
        run_op(2'b01, 0, "zerodiv");

        // Reset in the middle of WAIT.
        bus.req0_a = $urandom; bus.req0_b = 32'h3F800001;
        bus.req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req0_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst handshake", 32'(got), 32'd1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst div_a", div_a, 32'd0);
        check("midrst div_b", div_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_grant_m = 1'b1;
        repeat (S + 2) @(negedge clk);
        check("midrst no stale rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req0_a = 32'h40490FDB; bus.req0_b = 32'h402DF854;
        run_op(2'b01, 0, "after_reset");

        // Randomised traffic; pending requesters keep their data.
        for (int i = 0; i < 10; i++) begin
            if (!bus.req0_valid) begin
                bus.req0_a = $urandom;
                bus.req0_b = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h80000000) : $urandom;
            end
            if (!bus.req1_valid) begin
                bus.req1_a = $urandom;
                bus.req1_b = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h80000000) : $urandom;
            end
            vm = 2'($urandom_range(1, 3)) | {bus.req1_valid, bus.req0_valid};
            run_op(vm, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
- Sequencer and arbiter that shares one combinational 32-bit IEEE-754 single-precision divider (`div`) between two requesters.
- Accepts operand pairs over valid/ready handshakes and grants requesters round-robin.
- Holds the divider operands stable for a programmable settle time, then captures `result`/`Exception` into a registered response channel tagged with the requester ID.
- Sits between ALU issue logic and the `div` datapath.

Parameters:
- SETTLE_CYCLES, 4, cycles the divider operands are held before capture; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle
- req0_a  input  32  requester 0 dividend (IEEE-754 single)
- req0_b  input  32  requester 0 divisor
- req1_valid, req1_ready, req1_a, req1_b: same directions, widths and meanings for requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that owns the response
- rsp_result  output  32  quotient
- rsp_exception  output  1  divider Exception flag
- div_a  output  32  operand A to the divider
- div_b  output  32  operand B to the divider
- div_result  input  32  divider `result`
- div_exception  input  1  divider `Exception`
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - div_a, div_b, rsp_result = 0; rsp_valid, rsp_exception, rsp_id = 0.
  - counter=0; last_grant=1, so requester 0 has priority first.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Grant is combinational.
  - If both requesters are valid, grant the one that is not last_grant. Otherwise grant the single valid requester.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high per cycle.
  - On handshake: latch reqN_a/reqN_b into div_a/div_b, set id=N, last_grant=N, counter=SETTLE_CYCLES-1, go to WAIT.
- WAIT:
  - div_a/div_b are held stable.
  - Counter decrements each cycle.
  - When counter==0, register div_result into rsp_result and div_exception into rsp_exception, set rsp_id, set rsp_valid=1, go to DONE.
- DONE:
  - rsp_* are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE.
  - The next request may handshake on the cycle after return to IDLE; there is no same-cycle bypass.
- Latency: handshake on cycle T -> rsp_valid is high from cycle T+SETTLE_CYCLES+1 under the base configuration.
- Throughput: one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- Boundaries:
  - A requester dropping valid before ready is legal; no grant is issued to it.
  - req_valid asserted during WAIT/DONE is ignored (ready=0). Request data must remain stable until its handshake.
  - Back-to-back requests from both requesters alternate strictly 0,1,0,1.
  - rst asserted mid-operation aborts immediately to reset values; the in-flight response is discarded.
  - The Exception flag is passed through unchanged. The divider's result for 0/0, Inf and /0 is not altered, except under the optional feature.

Optional Feature:
- Macro: FP_DIV_ZERO_BYPASS_EN.
- Defined:
  - At handshake, if the granted divisor has bits[30:0]==0, skip WAIT and go directly to DONE next cycle.
  - In that case rsp_result={a[31]^b[31], 8'hFF, 23'd0} and rsp_exception=1; latency is 1 cycle.
  - div_a/div_b are still latched.
- Undefined: every request goes through WAIT; no divisor inspection logic is synthesized.

Test Plan:
- Reset: assert rst mid-WAIT -> busy=0, rsp_valid=0, div_a=div_b=0 asynchronously. After release, a req0 handshake completes normally.
- Single op: req0 a=0xC0B33333 (-5.6), b=0x40133333 (2.3), rsp_ready=1 -> ready pulses 1 cycle. rsp_valid exactly SETTLE_CYCLES+1 cycles later with rsp_id=0 and rsp_result=div_result sampled (model returns 0xC01BD37A ≈ -2.4348), rsp_exception=0.
- Contention: both requesters valid continuously for 4 ops -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; no op lost or duplicated.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_result and rsp_id stay constant, req_ready stays 0. Response completes on the first cycle rsp_ready=1.
- Divide by zero: req1 a=0x40B33333 (5.6), b=0x00000000.
  - Without macro: latency SETTLE_CYCLES+1; rsp_result and rsp_exception equal the divider outputs.
  - With FP_DIV_ZERO_BYPASS_EN: rsp_valid after 1 cycle, rsp_result=0x7F800000, rsp_exception=1.
- Zero dividend: a=0x00000000, b=0x40B33333 -> response equals the divider output (0x00000000), rsp_exception=0, in both configurations.
